// File: rtl/de10_linux_memtest_master_if.sv
// Avalon-MM master bus bundle for the memory test master.
// Ports (master view):
//   avm_address       out  ADDR_W  word address
//   avm_read          out  1       read request
//   avm_write         out  1       write request
//   avm_byteenable    out  4       byte lanes (all enabled)
//   avm_writedata     out  32      write data
//   avm_readdata      in   32      read data
//   avm_readdatavalid in   1       read data qualifier
//   avm_waitrequest   in   1       slave stall
interface de10_linux_memtest_master_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/de10_linux_memtest_master.sv
// Memory test master: writes a pattern over [base, base+length) (wrapping),
// reads it back with up to MAX_PEND reads outstanding and counts mismatches.
// Pattern: seed+k by default; a 32-bit Galois LFSR (mask 32'h80200003) when
// MEMTEST_LFSR_EN is defined.
// Ports:
//   clk, reset              clock, async active-high reset
//   start                   one-cycle pulse, accepted only when idle
//   base/length/seed        test window start, word count, pattern seed
//   busy/done               test in progress / one-cycle end pulse
//   error/err_count         sticky mismatch flag / saturating mismatch count
//   first_err_addr          address of the first mismatch of the test
//   avm                     Avalon-MM master bundle
module de10_linux_memtest_master #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       length,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  de10_linux_memtest_master_if.master avm
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  // Pattern generator shared by the write and compare paths.
  function automatic logic [DATA_W-1:0] pat_init(input logic [DATA_W-1:0] s);
`ifdef MEMTEST_LFSR_EN
    return (s == '0) ? DATA_W'(1) : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
`ifdef MEMTEST_LFSR_EN
    return (p >> 1) ^ (p[0] ? DATA_W'(32'h80200003) : '0);
`else
    return p + DATA_W'(1);
`endif
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_ret_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic [DATA_W-1:0]   r_exp;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    r_err_count;
  logic [ADDR_W-1:0]   r_first_err_addr;
  logic [ADDR_W-1:0]   r_avm_address;
  logic                r_avm_read;
  logic                r_avm_write;
  logic [DATA_W-1:0]   r_avm_writedata;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_ret;
  logic                w_mis;
  logic [PEND_W-1:0]   w_pend_nxt;
  logic [CNT_W-1:0]    w_rd_cnt_nxt;

  assign w_wr_acc     = r_avm_write & ~avm.avm_waitrequest;
  assign w_rd_acc     = r_avm_read  & ~avm.avm_waitrequest;
  // Returns only count while reads can be outstanding; stray ones are dropped.
  assign w_ret        = avm.avm_readdatavalid & (r_pending != '0) &
                        ((r_state == READ) || (r_state == DRAIN));
  assign w_mis        = w_ret & (avm.avm_readdata != r_exp);
  assign w_pend_nxt   = r_pending + PEND_W'(w_rd_acc) - PEND_W'(w_ret);
  assign w_rd_cnt_nxt = r_rd_cnt + CNT_W'(w_rd_acc);

  // Test sequencer, bus driver and read-back checker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_base           <= '0;
      r_len            <= '0;
      r_wr_cnt         <= '0;
      r_rd_cnt         <= '0;
      r_ret_cnt        <= '0;
      r_pending        <= '0;
      r_exp            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_avm_address    <= '0;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= '0;
    end else begin
      r_done <= 1'b0;

      // Returns complete in order, so the k-th return is checked against P(k).
      if (w_ret) begin
        r_exp     <= pat_next(r_exp);
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
        if (w_mis) begin
          r_error <= 1'b1;
          if (!(&r_err_count)) r_err_count <= r_err_count + CNT_W'(1);
          if (!r_error) r_first_err_addr <= r_base + ADDR_W'(r_ret_cnt);
        end
      end

      if ((r_state == READ) || (r_state == DRAIN)) r_pending <= w_pend_nxt;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_base           <= base;
            r_len            <= length;
            r_busy           <= 1'b1;
            r_error          <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_exp            <= pat_init(seed);
            r_wr_cnt         <= '0;
            r_rd_cnt         <= '0;
            r_ret_cnt        <= '0;
            r_pending        <= '0;
            if (length != '0) begin
              r_state         <= WRITE;
              r_avm_write     <= 1'b1;
              r_avm_address   <= base;
              r_avm_writedata <= pat_init(seed);
            end else begin
              r_state <= FINISH;
            end
          end
        end

        WRITE: begin
          if (w_wr_acc) begin
            if (r_wr_cnt == r_len - CNT_W'(1)) begin
              r_avm_write   <= 1'b0;
              r_avm_read    <= 1'b1;
              r_avm_address <= r_base;
              r_state       <= READ;
            end else begin
              r_wr_cnt        <= r_wr_cnt + CNT_W'(1);
              r_avm_address   <= r_avm_address + ADDR_W'(1);
              r_avm_writedata <= pat_next(r_avm_writedata);
            end
          end
        end

        READ: begin
          r_rd_cnt <= w_rd_cnt_nxt;
          if (w_rd_acc && (w_rd_cnt_nxt == r_len)) begin
            r_avm_read <= 1'b0;
            r_state    <= DRAIN;
          end else begin
            // A stalled read stays asserted: pending cannot grow while stalled.
            r_avm_read <= (w_pend_nxt < PEND_W'(MAX_PEND));
            if (w_rd_acc) r_avm_address <= r_avm_address + ADDR_W'(1);
          end
        end

        DRAIN: begin
          if (w_pend_nxt == '0) r_state <= FINISH;
        end

        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign error              = r_error;
  assign err_count          = r_err_count;
  assign first_err_addr     = r_first_err_addr;
  assign avm.avm_address    = r_avm_address;
  assign avm.avm_read       = r_avm_read;
  assign avm.avm_write      = r_avm_write;
  assign avm.avm_writedata  = 32'(r_avm_writedata);
  assign avm.avm_byteenable = 4'hF;

endmodule

// File: tb/tb_de10_linux_memtest_master.sv
// Directed bench for de10_linux_memtest_master with a behavioural Avalon
// memory (configurable stall, latency and fault injection).
module tb_de10_linux_memtest_master;
  localparam int unsigned ADDR_W = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base;
  logic [14:0] length;
  logic [31:0] seed;
  logic        busy, done, error;
  logic [14:0] err_count;
  logic [13:0] first_err_addr;

  de10_linux_memtest_master_if #(.ADDR_W(ADDR_W)) avm_if ();

  de10_linux_memtest_master #(.ADDR_W(ADDR_W), .DATA_W(32), .MAX_PEND(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
    .seed(seed), .busy(busy), .done(done), .error(error),
    .err_count(err_count), .first_err_addr(first_err_addr), .avm(avm_if)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] data; int due; } ret_t;
  logic [31:0] mem [0:16383];
  ret_t        rq[$];
  logic [13:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [13:0] rd_addr_q[$];
  bit          stall_en = 1'b0;
  int          lat = 1;
  int          fault_idx = -1;
  bit          corrupt_all = 1'b0;
  int          cyc = 0;
  bit          wphase = 1'b0;
  int          ret_idx = 0, outstanding = 0, max_pend = 0, n_both = 0, n_unstable = 0;
  bit          held = 1'b0;
  logic [13:0] h_addr;
  logic [31:0] h_data;
  logic        h_rd, h_wr;

  always @(negedge clk) begin
    ret_t r;
    cyc++;
    if (held && !reset) begin
      if (avm_if.avm_address !== h_addr || avm_if.avm_read !== h_rd ||
          avm_if.avm_write !== h_wr || (h_wr && avm_if.avm_writedata !== h_data))
        n_unstable++;
    end
    if (avm_if.avm_read === 1'b1 && avm_if.avm_write === 1'b1) n_both++;
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_readdata      = 32'hDEAD_BEEF;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata = r.data ^ ((ret_idx == fault_idx) ? 32'h1 : 32'h0)
                                   ^ (corrupt_all ? 32'hFFFF_FFFF : 32'h0);
      ret_idx++;
      outstanding--;
    end
    wphase = stall_en ? ~wphase : 1'b0;
    avm_if.avm_waitrequest = wphase;
    held   = (avm_if.avm_read === 1'b1 || avm_if.avm_write === 1'b1) && wphase;
    h_addr = avm_if.avm_address;
    h_data = avm_if.avm_writedata;
    h_rd   = avm_if.avm_read;
    h_wr   = avm_if.avm_write;
    if (reset === 1'b0 && !wphase) begin
      if (avm_if.avm_write === 1'b1) begin
        mem[avm_if.avm_address] = avm_if.avm_writedata;
        wr_addr_q.push_back(avm_if.avm_address);
        wr_data_q.push_back(avm_if.avm_writedata);
      end
      if (avm_if.avm_read === 1'b1) begin
        rd_addr_q.push_back(avm_if.avm_address);
        r.data = mem[avm_if.avm_address];
        r.due  = cyc + lat;
        rq.push_back(r);
        outstanding++;
        if (outstanding > max_pend) max_pend = outstanding;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_err = 0;
  int n_chk = 0;
  logic err_at_start;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_p(input logic [31:0] s, input int k);
    logic [31:0] p;
`ifdef MEMTEST_LFSR_EN
    p = (s == 32'h0) ? 32'h1 : s;
    for (int j = 0; j < k; j++) p = {1'b0, p[31:1]} ^ (p[0] ? 32'h80200003 : 32'h0);
`else
    p = s + 32'(k);
`endif
    return p;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    ret_idx = 0; max_pend = 0; n_both = 0; n_unstable = 0;
  endtask

  // Pulse start and wait (bounded) for done; returns cycles from start edge.
  task automatic run(input string tag, input logic [13:0] b, input logic [14:0] l,
                     input logic [31:0] s, output int cycles);
    clear_logs();
    @(negedge clk);
    base = b; length = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_at_start = error;
    cycles = 1;
    while (done !== 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc_n;
    int k;
    logic [13:0] wrap_a [4];
    wrap_a[0] = 14'd16382; wrap_a[1] = 14'd16383; wrap_a[2] = 14'd0; wrap_a[3] = 14'd1;
    reset = 1'b1; start = 1'b0; base = '0; length = '0; seed = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", {error, err_count, first_err_addr}, '0);
    chk("rst_bus", {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata}, '0);
    chk("byteenable", avm_if.avm_byteenable, 4'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // No-error run, base 0, length 8, seed 0x100
    run("s1", 14'd0, 15'd8, 32'h100, cyc_n);
    chk("s1_nwr", wr_addr_q.size(), 8);
    chk("s1_nrd", rd_addr_q.size(), 8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      chk("s1_wa", wr_addr_q[i], 14'(i));
      chk("s1_wd", wr_data_q[i], tb_p(32'h100, i));
    end
    for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) chk("s1_ra", rd_addr_q[i], 14'(i));
    chk("s1_err", {error, err_count}, '0);
    chk("s1_busy", busy, 1'b0);

    // Wrap-around
    run("s2", 14'd16382, 15'd4, 32'h55, cyc_n);
    chk("s2_nwr", wr_addr_q.size(), 4);
    chk("s2_nrd", rd_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) chk("s2_wa", wr_addr_q[i], wrap_a[i]);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) chk("s2_ra", rd_addr_q[i], wrap_a[i]);
    chk("s2_err", error, 1'b0);

    // Injected fault on returned word 5
    fault_idx = 5;
    run("s3", 14'd100, 15'd8, 32'h200, cyc_n);
    fault_idx = -1;
    chk("s3_error", error, 1'b1);
    chk("s3_cnt", err_count, 15'd1);
    chk("s3_first", first_err_addr, 14'd105);
    repeat (3) @(negedge clk);
    chk("s3_hold", {error, err_count, first_err_addr}, {1'b1, 15'd1, 14'd105});

    // Stalls on alternate cycles, 3-cycle read latency
    stall_en = 1'b1; lat = 3;
    run("s4", 14'd40, 15'd12, 32'hA5A5_0000, cyc_n);
    chk("s4_clear_on_start", err_at_start, 1'b0);
    chk("s4_nwr", wr_addr_q.size(), 12);
    chk("s4_nrd", rd_addr_q.size(), 12);
    for (int i = 0; i < 12 && i < wr_addr_q.size(); i++) chk("s4_wa", wr_addr_q[i], 14'(40 + i));
    for (int i = 0; i < 12 && i < rd_addr_q.size(); i++) chk("s4_ra", rd_addr_q[i], 14'(40 + i));
    chk("s4_pend_le4", (max_pend <= 4), 1'b1);
    chk("s4_stable", n_unstable, 0);
    chk("s4_rw_excl", n_both, 0);
    chk("s4_err", {error, err_count}, '0);

    // Long latency: read window fills to exactly MAX_PEND
    stall_en = 1'b0; lat = 8;
    run("s4b", 14'd200, 15'd8, 32'h7, cyc_n);
    chk("s4b_pend_max", max_pend, 4);
    chk("s4b_nrd", rd_addr_q.size(), 8);
    chk("s4b_err", error, 1'b0);

    // Zero length: done on the second cycle after start, no bus traffic
    lat = 1;
    run("s5", 14'd3, 15'd0, 32'h1, cyc_n);
    chk("s5_latency", cyc_n, 2);
    chk("s5_nbus", wr_addr_q.size() + rd_addr_q.size(), 0);
    chk("s5_busy", busy, 1'b0);

    // Reset pulsed during READ, stale returns then arrive while idle
    lat = 3;
    clear_logs();
    @(negedge clk);
    base = 14'd300; length = 15'd16; seed = 32'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (avm_if.avm_read !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("s6_reached_read", avm_if.avm_read, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s6_rst_ctl", {busy, done, error, err_count, first_err_addr}, '0);
    chk("s6_rst_bus", {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata}, '0);
    corrupt_all = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
    corrupt_all = 1'b0;
    chk("s6_no_done", k, 0);
    chk("s6_idle_ignore", {busy, error, err_count}, '0);

    // Seed 0, length 2: first two pattern words
    lat = 1;
    run("s7", 14'd0, 15'd2, 32'h0, cyc_n);
    chk("s7_nwr", wr_data_q.size(), 2);
`ifdef MEMTEST_LFSR_EN
    if (wr_data_q.size() == 2) begin
      chk("s7_wd0", wr_data_q[0], 32'h1);
      chk("s7_wd1", wr_data_q[1], 32'h8020_0003);
    end
`else
    if (wr_data_q.size() == 2) begin
      chk("s7_wd0", wr_data_q[0], 32'h0);
      chk("s7_wd1", wr_data_q[1], 32'h1);
    end
`endif
    chk("s7_err", error, 1'b0);
    chk("all_rw_excl", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
